mux_fifo_n: RTL and testbench



---
 rtl/mux_fifo_n.sv | 132 +++++++++++++
 tb/tb_mux_fifo_n.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux_fifo_n.sv
// rtl/mux_fifo_n.sv - N-channel buffered output multiplexer with valid/ready back-pressure
//
// Each input channel writes into its own circular FIFO. Only the channel named
// by select is drained into a single registered output stage.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   select      index of the channel to drain (values >= N_CH drain nothing)
//   data_i      packed input words, channel k at [k*D_WIDTH +: D_WIDTH]
//   valid_i     per-channel input valid
//   ready_o     per-channel space available (0 while in reset)
//   data_o      registered output word
//   valid_o     registered output valid
//   ready_i     downstream accepts data_o this cycle
//   overflow_o  sticky per-channel dropped-write flag
module mux_fifo_n #(
   parameter int D_WIDTH   = 8,
   parameter int N_CH      = 4,
   parameter int SEL_WIDTH = 2,
   parameter int DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SEL_WIDTH-1:0]      select,
   input  logic [N_CH*D_WIDTH-1:0]   data_i,
   input  logic [N_CH-1:0]           valid_i,
   output logic [N_CH-1:0]           ready_o,
   output logic [D_WIDTH-1:0]        data_o,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [N_CH-1:0]           overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [D_WIDTH-1:0] mem    [N_CH][DEPTH];
   logic [AW-1:0]      wr_ptr [N_CH];
   logic [AW-1:0]      rd_ptr [N_CH];
   logic [CW-1:0]      count  [N_CH];

   logic [N_CH-1:0]    push;
   logic [N_CH-1:0]    pop_ch;
   logic [D_WIDTH-1:0] head;
   logic               sel_nonempty;
   logic               load_ok;
   logic               pop;
   int                 sel_int;

   assign sel_int = int'(select);
   assign load_ok = !valid_o || ready_i;
   assign pop     = load_ok && sel_nonempty;

   // Space flag depends only on the registered count, so a full FIFO refuses
   // a write even in the cycle it is being popped.
   always_comb begin
      ready_o = '0;
      push    = '0;
      for (int k = 0; k < N_CH; k++) begin
         ready_o[k] = rst_n && (count[k] != FULL);
         push[k]    = valid_i[k] && ready_o[k];
      end
   end

   // Head-of-queue lookup; an out-of-range select matches no channel and so
   // reads as empty, which suppresses any pop.
   always_comb begin
      head         = '0;
      sel_nonempty = 1'b0;
      pop_ch       = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (sel_int == k) begin
            head         = mem[k][rd_ptr[k]];
            sel_nonempty = (count[k] != '0);
            pop_ch[k]    = pop;
         end
      end
   end

   // Storage needs no reset: stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      for (int k = 0; k < N_CH; k++) begin
         if (push[k]) begin
            mem[k][wr_ptr[k]] <= data_i[k*D_WIDTH +: D_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N_CH; k++) begin
            wr_ptr[k] <= '0;
            rd_ptr[k] <= '0;
            count[k]  <= '0;
         end
         overflow_o <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (push[k]) begin
               wr_ptr[k] <= wr_ptr[k] + 1'b1;
            end
            if (pop_ch[k]) begin
               rd_ptr[k] <= rd_ptr[k] + 1'b1;
            end
            case ({push[k], pop_ch[k]})
               2'b10:   count[k] <= count[k] + 1'b1;
               2'b01:   count[k] <= count[k] - 1'b1;
               default: count[k] <= count[k];
            endcase
            if (valid_i[k] && (count[k] == FULL)) begin
               overflow_o[k] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_o  <= '0;
         valid_o <= 1'b0;
      end else if (pop) begin
         data_o  <= head;
         valid_o <= 1'b1;
      end else if (ready_i) begin
         // Current word accepted with nothing to replace it: drain.
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_fifo_n.sv
// tb/tb_mux_fifo_n.sv - scoreboard testbench for mux_fifo_n
module tb_mux_fifo_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  select;
   logic [31:0] data_i;
   logic [3:0]  valid_i;
   logic [3:0]  ready_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;
   logic [3:0]  overflow_o;

   logic [1:0]  sel3;
   logic [23:0] data3;
   logic [2:0]  valid3;
   logic [2:0]  ready3_o;
   logic [7:0]  data_o3;
   logic        valid_o3;
   logic        ready_i3;
   logic [2:0]  ovf3;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   mux_fifo_n #(.D_WIDTH(8), .N_CH(4), .SEL_WIDTH(2), .DEPTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .select(select), .data_i(data_i),
      .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o),
      .valid_o(valid_o), .ready_i(ready_i), .overflow_o(overflow_o)
   );

   mux_fifo_n #(.D_WIDTH(8), .N_CH(3), .SEL_WIDTH(2), .DEPTH(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .select(sel3), .data_i(data3),
      .valid_i(valid3), .ready_o(ready3_o), .data_o(data_o3),
      .valid_o(valid_o3), .ready_i(ready_i3), .overflow_o(ovf3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int ch, input logic [7:0] val);
      data_i[ch*8 +: 8] = val;
      valid_i[ch]       = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: a handshake completes at the next rising edge whenever
   // valid_o && ready_i is seen here.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_word", {24'h0, data_o}, 32'hFFFF_FFFF);
         end else begin
            check("sb_data", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      rst_n = 1'b0; select = '0; data_i = '0; valid_i = '0; ready_i = 1'b0;
      sel3 = '0; data3 = '0; valid3 = '0; ready_i3 = 1'b0;
      tick(); tick();
      check("rst_ready_low", ready_o, 4'h0);
      check("rst_valid", valid_o, 0);
      check("rst_data", data_o, 0);
      check("rst_ovf", overflow_o, 0);
      rst_n = 1'b1;
      #1;
      check("rst_ready_after", ready_o, 4'hF);

      // Basic pass-through on channel 2
      select = 2; ready_i = 1'b1;
      put(2, 8'h41); exp_q.push_back(8'h41); tick();
      put(2, 8'h42); exp_q.push_back(8'h42); tick();
      check("pt_latency_valid", valid_o, 1);
      check("pt_latency_data", data_o, 8'h41);
      valid_i = '0; tick();
      check("pt_second_valid", valid_o, 1);
      check("pt_second_data", data_o, 8'h42);
      tick();
      check("pt_drained", valid_o, 0);
      drain("pt_drain");

      // Buffering while unselected
      select = 0;
      for (int i = 0; i < 3; i++) begin
         put(1, 8'h10 + 8'(i)); tick();
         check("buf_valid_low", valid_o, 0);
         check("buf_ready1", ready_o[1], 1);
      end
      valid_i = '0;
      exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
      select = 1;
      drain("buf_drain");
      check("buf_end_valid", valid_o, 0);

      // Full and overflow on channel 3
      select = 3; ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         put(3, 8'hA0 + 8'(i)); tick();
      end
      check("full_ready3", ready_o[3], 0);
      check("full_ovf_clear", overflow_o[3], 0);
      check("full_out_valid", valid_o, 1);
      check("full_out_data", data_o, 8'hA0);
      put(3, 8'hA5); tick();
      valid_i = '0;
      check("ovf_set", overflow_o[3], 1);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
      ready_i = 1'b1;
      drain("full_drain");
      tick();
      check("full_no_a5", valid_o, 0);

      // Stall and select change
      select = 0; ready_i = 1'b0;
      put(0, 8'h55); put(1, 8'h66); tick();
      valid_i = '0; tick();
      check("stall_load_data", data_o, 8'h55);
      select = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_hold_valid", valid_o, 1);
         check("stall_hold_data", data_o, 8'h55);
      end
      exp_q.push_back(8'h55); exp_q.push_back(8'h66);
      ready_i = 1'b1; tick();
      check("sel_next_data", data_o, 8'h66);
      drain("sel_drain");

      // Out-of-range select on the 3-channel instance
      sel3 = 2'd3; ready_i3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data3[7:0]   = 8'h40 + 8'(i);
         data3[15:8]  = 8'h50 + 8'(i);
         data3[23:16] = 8'h60 + 8'(i);
         valid3 = 3'b111; tick();
      end
      valid3 = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("oor_valid_low", valid_o3, 0);
         check("oor_counts_full", ready3_o, 3'b000);
      end
      sel3 = 2'd0; tick();
      check("oor_then_sel0_valid", valid_o3, 1);
      check("oor_then_sel0_data", data_o3, 8'h40);

      // Reset mid-operation
      select = 0; ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         put(0, 8'hB0 + 8'(i)); tick();
      end
      valid_i = '0;
      check("mid_ovf0", overflow_o[0], 1);
      exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
      ready_i = 1'b1; tick(); tick();
      ready_i = 1'b0;
      check("mid_hold_data", data_o, 8'hB2);
      check("mid_hold_valid", valid_o, 1);
      check("mid_sb_empty", exp_q.size(), 0);
      rst_n = 1'b0; tick();
      check("mid_rst_valid", valid_o, 0);
      check("mid_rst_data", data_o, 0);
      check("mid_rst_ovf", overflow_o, 0);
      check("mid_rst_ready", ready_o, 4'h0);
      rst_n = 1'b1;
      #1;
      check("mid_rel_ready", ready_o, 4'hF);
      ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("mid_no_stale", valid_o, 0);
      end
      check("final_sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
